// File: rtl/arduino_tx_link_pkg.sv
// -----------------------------------------------------------------------------
// arduino_tx_link_pkg
// Shared definitions for the FPGA/Arduino parallel link (transmit and receive
// sides): handshake state encoding, default link dimensions and a small
// counter-width helper.
// -----------------------------------------------------------------------------
package arduino_tx_link_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RELEASE = 2'd3
  } link_state_e;

  localparam int DATA_W_DEF      = 12;
  localparam int SETUP_CYC_DEF   = 4;
  localparam int TIMEOUT_CYC_DEF = 50000;
  localparam int SYNC_STAGES_DEF = 2;

  // Width of a counter that must hold values 0 .. n-1 (at least 1 bit).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arduino_tx_link_sync_ff.sv
// -----------------------------------------------------------------------------
// arduino_tx_link_sync_ff
// Flop-chain synchronizer for asynchronous Arduino inputs.
// Ports:
//   clk_i  in   system clock, rising edge
//   reset  in   synchronous active-high reset, clears every stage
//   d      in   asynchronous input
//   q      out  input after STAGES flops
// -----------------------------------------------------------------------------
module arduino_tx_link_sync_ff
  import arduino_tx_link_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF,
  parameter int W      = 1
) (
  input  logic         clk_i,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [STAGES-1:0][W-1:0] chain;

  always_ff @(posedge clk_i) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/arduino_tx_link.sv
// -----------------------------------------------------------------------------
// arduino_tx_link
// Transmit side of the FPGA/Arduino parallel link. Accepts one word at a time
// over valid/ready and presents it to the Arduino with a four-phase
// request/acknowledge handshake (dataf_o = request, ack_i = acknowledge).
// Ports:
//   clk_i      in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   data_i     in   word to send
//   send_i     in   valid: a word is offered
//   ready_o    out  block can accept a word (IDLE)
//   arduino_o  out  parallel bus to the Arduino, stable while busy
//   dataf_o    out  data flag (request) to the Arduino
//   ack_i      in   asynchronous acknowledge from the Arduino
//   done_o     out  one-cycle pulse on normal completion
//   timeout_o  out  one-cycle pulse when a transaction is aborted
//
// state   | meaning
// IDLE    | waiting for send_i, ready_o high
// SETUP   | word driven, waiting setup time and for ack_s low
// STROBE  | dataf_o high, waiting for ack_s high
// RELEASE | dataf_o low, waiting for ack_s low to finish
// -----------------------------------------------------------------------------
module arduino_tx_link
  import arduino_tx_link_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SETUP_CYC   = SETUP_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk_i,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_i,
  input  logic              send_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] arduino_o,
  output logic              dataf_o,
  input  logic              ack_i,
  output logic              done_o,
  output logic              timeout_o
);

  localparam int PH_W = cnt_w(SETUP_CYC);
  localparam int TO_W = cnt_w(TIMEOUT_CYC);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SETUP_CYC - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  link_state_e     state;
  logic [PH_W-1:0] ph_cnt;
  logic [TO_W-1:0] to_cnt;
  logic            ack_s;

  arduino_tx_link_sync_ff #(
    .STAGES (SYNC_STAGES),
    .W      (1)
  ) u_ack_sync (
    .clk_i (clk_i),
    .reset (reset),
    .d     (ack_i),
    .q     (ack_s)
  );

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state     <= IDLE;
      ph_cnt    <= '0;
      to_cnt    <= '0;
      arduino_o <= '0;
      dataf_o   <= 1'b0;
      done_o    <= 1'b0;
      timeout_o <= 1'b0;
      ready_o   <= 1'b0;
    end else begin
      done_o    <= 1'b0;
      timeout_o <= 1'b0;

      // Timeout counter runs while busy; it stops at its last value so it can
      // never wrap, and is cleared again on the next acceptance.
      if (state != IDLE && to_cnt != TO_LAST) begin
        to_cnt <= to_cnt + TO_W'(1);
      end

      unique case (state)
        IDLE: begin
          ready_o <= 1'b1;
          if (send_i && ready_o) begin
            arduino_o <= data_i;
            ph_cnt    <= '0;
            to_cnt    <= '0;
            ready_o   <= 1'b0;
            state     <= SETUP;
          end
        end

        SETUP: begin
          // Phase count saturates so a stale ack only delays the strobe
          // instead of missing the setup-done compare forever.
          if (ph_cnt != PH_LAST) begin
            ph_cnt <= ph_cnt + PH_W'(1);
          end
          if (ph_cnt == PH_LAST && !ack_s) begin
            dataf_o <= 1'b1;
            state   <= STROBE;
          end else if (to_cnt == TO_LAST) begin
            state     <= IDLE;
            ready_o   <= 1'b1;
            timeout_o <= 1'b1;
          end
        end

        STROBE: begin
          if (ack_s) begin
            dataf_o <= 1'b0;
            state   <= RELEASE;
          end else if (to_cnt == TO_LAST) begin
            dataf_o   <= 1'b0;
            state     <= IDLE;
            ready_o   <= 1'b1;
            timeout_o <= 1'b1;
          end
        end

        RELEASE: begin
          // Completion is checked first so it wins a tie with the timeout.
          if (!ack_s) begin
            state   <= IDLE;
            ready_o <= 1'b1;
            done_o  <= 1'b1;
          end else if (to_cnt == TO_LAST) begin
            state     <= IDLE;
            ready_o   <= 1'b1;
            timeout_o <= 1'b1;
          end
        end

        default: begin
          dataf_o <= 1'b0;
          ready_o <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arduino_tx_link.sv
module tb_arduino_tx_link;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Default-parameter instance
  logic [11:0] d0_data = '0;
  logic        d0_send = 1'b0;
  logic        d0_ack  = 1'b0;
  logic        d0_ready, d0_dataf, d0_done, d0_to;
  logic [11:0] d0_arduino;

  // TIMEOUT_CYC = 20 instance
  logic [11:0] t_data = '0;
  logic        t_send = 1'b0;
  logic        t_ack  = 1'b0;
  logic        t_ready, t_dataf, t_done, t_to;
  logic [11:0] t_arduino;

  // TIMEOUT_CYC = 10 instance, tuned so ack_s falls on the last count edge
  logic [11:0] k_data = '0;
  logic        k_send = 1'b0;
  logic        k_ack  = 1'b0;
  logic        k_ready, k_dataf, k_done, k_to;
  logic [11:0] k_arduino;

  arduino_tx_link dut (
    .clk_i (clk), .reset (reset), .data_i (d0_data), .send_i (d0_send),
    .ready_o (d0_ready), .arduino_o (d0_arduino), .dataf_o (d0_dataf),
    .ack_i (d0_ack), .done_o (d0_done), .timeout_o (d0_to)
  );

  arduino_tx_link #(.TIMEOUT_CYC(20)) dut_to20 (
    .clk_i (clk), .reset (reset), .data_i (t_data), .send_i (t_send),
    .ready_o (t_ready), .arduino_o (t_arduino), .dataf_o (t_dataf),
    .ack_i (t_ack), .done_o (t_done), .timeout_o (t_to)
  );

  arduino_tx_link #(.TIMEOUT_CYC(10)) dut_tie (
    .clk_i (clk), .reset (reset), .data_i (k_data), .send_i (k_send),
    .ready_o (k_ready), .arduino_o (k_arduino), .dataf_o (k_dataf),
    .ack_i (k_ack), .done_o (k_done), .timeout_o (k_to)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (d0_arduino !== 12'h000 || d0_dataf !== 1'b0 || d0_done !== 1'b0 || d0_to !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: arduino=%h dataf=%b done=%b timeout=%b expected 000 0 0 0",
               d0_arduino, d0_dataf, d0_done, d0_to);
    end
    checks++;
    if (t_arduino !== 12'h000 || t_dataf !== 1'b0 || k_arduino !== 12'h000 || k_dataf !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs_other: t_arduino=%h t_dataf=%b k_arduino=%h k_dataf=%b expected zeros",
               t_arduino, t_dataf, k_arduino, k_dataf);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (d0_ready !== 1'b1 || t_ready !== 1'b1 || k_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: ready=%b/%b/%b expected 1/1/1", d0_ready, t_ready, k_ready);
    end
  endtask

  task automatic test_nominal;
    d0_data = 12'hA5C;
    d0_send = 1'b1;
    tick();  // acceptance edge A
    d0_send = 1'b0;
    checks++;
    if (d0_arduino !== 12'hA5C || d0_ready !== 1'b0 || d0_dataf !== 1'b0) begin
      failures++;
      $display("FAIL nominal_accept: arduino=%h ready=%b dataf=%b expected A5C 0 0",
               d0_arduino, d0_ready, d0_dataf);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (d0_dataf !== 1'(i == 4) || d0_arduino !== 12'hA5C) begin
        failures++;
        $display("FAIL nominal_setup A+%0d: dataf=%b arduino=%h expected %b A5C",
                 i, d0_dataf, d0_arduino, 1'(i == 4));
      end
    end
    repeat (3) tick();
    d0_ack = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (d0_dataf !== 1'(i < 3)) begin
        failures++;
        $display("FAIL nominal_strobe_fall +%0d: dataf=%b expected %b", i, d0_dataf, 1'(i < 3));
      end
    end
    repeat (3) tick();
    d0_ack = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (d0_done !== 1'(i == 3) || d0_ready !== 1'(i == 3) || d0_to !== 1'b0) begin
        failures++;
        $display("FAIL nominal_done +%0d: done=%b ready=%b timeout=%b expected %b %b 0",
                 i, d0_done, d0_ready, d0_to, 1'(i == 3), 1'(i == 3));
      end
    end
    tick();
    checks++;
    if (d0_done !== 1'b0 || d0_ready !== 1'b1 || d0_arduino !== 12'hA5C) begin
      failures++;
      $display("FAIL nominal_after: done=%b ready=%b arduino=%h expected 0 1 A5C",
               d0_done, d0_ready, d0_arduino);
    end
  endtask

  task automatic test_stale_ack;
    d0_ack = 1'b1;
    repeat (3) tick();
    d0_data = 12'h123;
    d0_send = 1'b1;
    tick();  // A
    d0_send = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (d0_dataf !== 1'b0 || d0_arduino !== 12'h123) begin
        failures++;
        $display("FAIL stale_hold A+%0d: dataf=%b arduino=%h expected 0 123", i, d0_dataf, d0_arduino);
      end
    end
    d0_ack = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (d0_dataf !== 1'(i == 3)) begin
        failures++;
        $display("FAIL stale_rise +%0d: dataf=%b expected %b", i, d0_dataf, 1'(i == 3));
      end
    end
    d0_ack = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (d0_dataf !== 1'(i < 3)) begin
        failures++;
        $display("FAIL stale_fall +%0d: dataf=%b expected %b", i, d0_dataf, 1'(i < 3));
      end
    end
    d0_ack = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (d0_done !== 1'(i == 3)) begin
        failures++;
        $display("FAIL stale_done +%0d: done=%b expected %b", i, d0_done, 1'(i == 3));
      end
    end
  endtask

  task automatic test_timeout;
    t_data = 12'hFFF;
    t_send = 1'b1;
    tick();  // A
    t_send = 1'b0;
    for (int i = 1; i <= 19; i++) begin
      tick();
      checks++;
      if (t_dataf !== 1'(i >= 4) || t_to !== 1'b0 || t_done !== 1'b0 || t_arduino !== 12'hFFF) begin
        failures++;
        $display("FAIL timeout_run A+%0d: dataf=%b timeout=%b done=%b arduino=%h expected %b 0 0 FFF",
                 i, t_dataf, t_to, t_done, t_arduino, 1'(i >= 4));
      end
    end
    tick();  // A+20
    checks++;
    if (t_to !== 1'b1 || t_dataf !== 1'b0 || t_ready !== 1'b1 || t_done !== 1'b0 || t_arduino !== 12'hFFF) begin
      failures++;
      $display("FAIL timeout_fire: timeout=%b dataf=%b ready=%b done=%b arduino=%h expected 1 0 1 0 FFF",
               t_to, t_dataf, t_ready, t_done, t_arduino);
    end
    tick();
    checks++;
    if (t_to !== 1'b0 || t_done !== 1'b0 || t_ready !== 1'b1 || t_arduino !== 12'hFFF) begin
      failures++;
      $display("FAIL timeout_after: timeout=%b done=%b ready=%b arduino=%h expected 0 0 1 FFF",
               t_to, t_done, t_ready, t_arduino);
    end
  endtask

  task automatic test_reset_mid_strobe;
    d0_data = 12'h5A5;
    d0_send = 1'b1;
    tick();
    d0_send = 1'b0;
    repeat (4) tick();
    checks++;
    if (d0_dataf !== 1'b1) begin
      failures++;
      $display("FAIL rst_strobe_pre: dataf=%b expected 1", d0_dataf);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (d0_arduino !== 12'h000 || d0_dataf !== 1'b0 || d0_done !== 1'b0 || d0_to !== 1'b0) begin
      failures++;
      $display("FAIL rst_strobe_clear: arduino=%h dataf=%b done=%b timeout=%b expected 000 0 0 0",
               d0_arduino, d0_dataf, d0_done, d0_to);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (d0_ready !== 1'b1 || d0_dataf !== 1'b0 || d0_done !== 1'b0 || d0_to !== 1'b0) begin
      failures++;
      $display("FAIL rst_strobe_release: ready=%b dataf=%b done=%b timeout=%b expected 1 0 0 0",
               d0_ready, d0_dataf, d0_done, d0_to);
    end
    tick();
    checks++;
    if (d0_done !== 1'b0 || d0_to !== 1'b0 || d0_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_strobe_quiet: done=%b timeout=%b ready=%b expected 0 0 1", d0_done, d0_to, d0_ready);
    end
  endtask

  task automatic test_busy_rejection;
    d0_data = 12'h3C3;
    d0_send = 1'b1;
    tick();  // A
    d0_send = 1'b0;
    repeat (4) tick();
    d0_data = 12'h0F0;
    d0_send = 1'b1;
    tick();  // A+5, pulse while in STROBE
    d0_send = 1'b0;
    checks++;
    if (d0_arduino !== 12'h3C3 || d0_ready !== 1'b0 || d0_dataf !== 1'b1) begin
      failures++;
      $display("FAIL busy_pulse: arduino=%h ready=%b dataf=%b expected 3C3 0 1", d0_arduino, d0_ready, d0_dataf);
    end
    d0_ack = 1'b1;
    repeat (3) tick();  // A+8, RELEASE
    d0_send = 1'b1;
    d0_ack = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (d0_arduino !== 12'h3C3 || d0_done !== 1'(i == 3) || d0_ready !== 1'(i == 3)) begin
        failures++;
        $display("FAIL busy_done +%0d: arduino=%h done=%b ready=%b expected 3C3 %b %b",
                 i, d0_arduino, d0_done, d0_ready, 1'(i == 3), 1'(i == 3));
      end
    end
    tick();  // B, accepted on first edge with ready high
    d0_send = 1'b0;
    checks++;
    if (d0_arduino !== 12'h0F0 || d0_ready !== 1'b0 || d0_done !== 1'b0) begin
      failures++;
      $display("FAIL busy_accept: arduino=%h ready=%b done=%b expected 0F0 0 0", d0_arduino, d0_ready, d0_done);
    end
    repeat (4) tick();
    checks++;
    if (d0_dataf !== 1'b1 || d0_arduino !== 12'h0F0) begin
      failures++;
      $display("FAIL busy_second_strobe: dataf=%b arduino=%h expected 1 0F0", d0_dataf, d0_arduino);
    end
    d0_ack = 1'b1;
    repeat (3) tick();
    d0_ack = 1'b0;
    repeat (3) tick();
    checks++;
    if (d0_done !== 1'b1 || d0_ready !== 1'b1) begin
      failures++;
      $display("FAIL busy_second_done: done=%b ready=%b expected 1 1", d0_done, d0_ready);
    end
  endtask

  task automatic test_tie;
    k_data = 12'h7E1;
    k_send = 1'b1;
    tick();  // A
    k_send = 1'b0;
    repeat (4) tick();
    checks++;
    if (k_dataf !== 1'b1) begin
      failures++;
      $display("FAIL tie_strobe: dataf=%b expected 1", k_dataf);
    end
    k_ack = 1'b1;
    repeat (3) tick();  // A+7
    checks++;
    if (k_dataf !== 1'b0) begin
      failures++;
      $display("FAIL tie_release: dataf=%b expected 0", k_dataf);
    end
    k_ack = 1'b0;
    repeat (2) tick();  // A+9
    checks++;
    if (k_done !== 1'b0 || k_to !== 1'b0) begin
      failures++;
      $display("FAIL tie_pre: done=%b timeout=%b expected 0 0", k_done, k_to);
    end
    tick();  // A+10: completion and final count coincide
    checks++;
    if (k_done !== 1'b1 || k_to !== 1'b0 || k_ready !== 1'b1) begin
      failures++;
      $display("FAIL tie_edge: done=%b timeout=%b ready=%b expected 1 0 1", k_done, k_to, k_ready);
    end
    tick();
    checks++;
    if (k_done !== 1'b0 || k_to !== 1'b0) begin
      failures++;
      $display("FAIL tie_after: done=%b timeout=%b expected 0 0", k_done, k_to);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stale_ack();
    test_timeout();
    test_reset_mid_strobe();
    test_busy_rejection();
    test_tie();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
